echo_stream_core: RTL and testbench
===================================

Name: echo_stream_core

Overview:
- Parametrised streaming echo engine; successor to the record/process/play echo block.
- Replaces fixed-size batch memories with a circular delay line, signed multi-bit samples, a runtime-programmable delay, a decay shift, and an optional feedback (multi-tap) mode.
- Sits between the ADC deserialiser and the DAC/visualiser path.
- Valid/ready on both sides; one sample per accepted handshake.

Parameters:
- DATA_W, 16, signed sample width.
- ADDR_W, 10, delay-line address width; line holds DEPTH = 2^ADDR_W samples.
- DECAY_SHIFT, 1, arithmetic right shift applied to the delayed sample (gain 2^-DECAY_SHIFT).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- en  in  1  start/continue streaming; deassert to request flush
- delay  in  ADDR_W  echo delay in samples; sampled only in IDLE when en=1
- fb_mode  in  1  0 = single echo (store x), 1 = feedback (store y); sampled with delay
- in_valid  in  1  input sample valid
- in_ready  out  1  core accepts input
- in_data  in  DATA_W  signed input sample x
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_W  signed output sample y
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when flush completes

Behaviour:
- Reset (rst=0 at posedge clk): state IDLE; write pointer, fill count and flush count = 0; out_valid=0; out_data=0; done=0; busy=0; in_ready=0. Delay-line contents are not cleared; the fill count masks them.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0. When en=1: latch delay → D and fb_mode → FB; clear fill count and write pointer; go to RUN next cycle.
- RUN: in_ready = !out_valid || out_ready (one-entry output register, no bubble at full rate).
  - On handshake with sample x: tap t = line[(wp - D) mod DEPTH] if fill ≥ D, else 0.
  - y = sat(x + (t >>> DECAY_SHIFT)).
  - Write line[wp] = FB ? y : x; wp++ (wraps mod DEPTH).
  - fill++ (saturates at DEPTH-1).
  - out_data=y; out_valid=1 the following cycle (latency 1 clock).
- Output register: out_valid holds until out_ready=1. A new y may load in the same cycle the old one is taken.
- D=0: bypass, y=x; nothing written; fill not incremented.
- Saturation: the sum is computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Tap read: the write to line[wp] and the read of line[wp-D] never alias for D≥1. For D ≥ DEPTH the latched value is truncated by width, so this cannot occur.
- en=0 in RUN: go to FLUSH after any in-flight handshake completes.
  - Flush count = min(fill, D) if FB=0; if FB=1, count = DEPTH (bounded tail).
  - D=0: flush count = 0.
- FLUSH: in_ready=0. Inject internal x=0 samples at the same rate (gated by output-register availability), same datapath, one output per injection. Decrement flush count on each; when it reaches 0, go to DONE.
- DONE: wait until out_valid=0 (last sample drained), then pulse done=1 for one cycle and return to IDLE.
- en toggling during FLUSH/DONE is ignored; a new run starts only from IDLE.
- Reset mid-operation: the state machine and counters re-initialise immediately. The pending output sample is discarded (out_valid=0 next cycle).
- delay and fb_mode changes outside IDLE have no effect until the next run.
- Back-pressure: out_ready=0 stalls RUN (in_ready=0) and FLUSH with no sample lost or duplicated.

Test Plan:
- Single echo: DATA_W=16, DECAY_SHIFT=1, D=4, FB=0; impulse x=1000 then zeros, out_ready=1 → y = 1000,0,0,0,500,0,... Tail of 4 flush samples, then done pulses once.
- Feedback: D=3, FB=1, impulse 1024 → y=1024 at n=0, 512 at n=3, 256 at n=6, 128 at n=9; flush emits DEPTH samples before done.
- Saturation: D=1, FB=0, constant x=30000 → first y=30000, then every y=32767; x=-30000 → every y after the first = -32768.
- Back-pressure: random out_ready at 50% with D=8 → output sequence identical to the out_ready=1 run; in_ready=0 whenever out_valid=1 and out_ready=0.
- Wrap-around: ADDR_W=4, D=15, 40 ramp samples x=n → y(n) = n + ((n-15)>>>1) for n≥15; pointer wraps twice with no glitch.
- Reset/bypass: assert rst=0 mid-RUN → out_valid=0 and busy=0 next cycle. Restart with D=0 → y=x exactly, done follows immediately after en drops.

Source files
------------

// File: rtl/echo_stream_core.sv
// echo_stream_core: streaming echo over a circular delay line with decay, saturation and optional feedback.
module echo_stream_core #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [ADDR_W-1:0]        delay_i,
    input  logic                     fb_mode_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] out_data_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d, fill_q, fill_d, fill_inc, d_q, d_d;
    logic fb_q, fb_d;
    logic [ADDR_W:0] flush_q, flush_d, flush_cnt;
    logic out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic signed [DATA_W-1:0] line_q [DEPTH];
    logic avail, fire, wr;
    logic signed [DATA_W-1:0] x, tap, y;
    logic signed [DATA_W:0] sum;
    assign avail       = !out_valid_q || out_ready_i;
    assign in_ready_o  = (state_q == RUN) && avail;
    assign fire        = (in_valid_i && in_ready_o) || (state_q == FLUSH && avail && flush_q != '0);
    assign wr          = fire && d_q != '0;
    assign x           = (state_q == FLUSH) ? '0 : in_data_i;
    // fill >= D guarantees the tapped slot was written during this run
    assign tap         = (d_q != '0 && fill_q >= d_q) ? line_q[wp_q - d_q] : '0;
    assign sum         = {x[DATA_W-1], x} + {tap[DATA_W-1], tap >>> DECAY_SHIFT};
    assign y           = (sum[DATA_W] != sum[DATA_W-1]) ? (sum[DATA_W] ? MIN_V : MAX_V) : sum[DATA_W-1:0];
    assign fill_inc    = (wr && fill_q != '1) ? fill_q + 1'b1 : fill_q;
    assign flush_cnt   = (d_q == '0) ? '0 : fb_q ? (ADDR_W+1)'(DEPTH) : {1'b0, (fill_inc < d_q) ? fill_inc : d_q};
    assign out_valid_d = fire ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
    assign out_data_d  = fire ? y : out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        wp_d    = wr ? wp_q + 1'b1 : wp_q;
        fill_d  = fill_inc;
        d_d     = d_q;
        fb_d    = fb_q;
        flush_d = (state_q == FLUSH && fire) ? flush_q - 1'b1 : flush_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: if (en_i) begin
                d_d     = delay_i;
                fb_d    = fb_mode_i;
                wp_d    = '0;
                fill_d  = '0;
                state_d = RUN;
            end
            RUN: if (!en_i) begin
                flush_d = flush_cnt;
                state_d = (flush_cnt == '0) ? DONE : FLUSH;
            end
            FLUSH: if (fire && flush_q == (ADDR_W+1)'(1)) state_d = DONE;
            DONE: if (!out_valid_q) begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            fill_q      <= '0;
            flush_q     <= '0;
            d_q         <= '0;
            fb_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            flush_q     <= flush_d;
            d_q         <= d_d;
            fb_q        <= fb_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) line_q[wp_q] <= fb_q ? y : x;
    end
endmodule

// File: tb/tb_echo_stream_core.sv
// tb_echo_stream_core: randomized streams against a sample-index echo model.
module tb_echo_stream_core;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int SH = 1;
    localparam int DEPTH = 1 << AW;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, fb = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [AW-1:0] delay = '0;
    logic signed [DW-1:0] in_data = '0;
    logic signed [DW-1:0] out_data;
    logic in_ready, out_valid, busy, done;
    int checks = 0, errors = 0, bp_viol = 0;
    echo_stream_core #(.DATA_W(DW), .ADDR_W(AW), .DECAY_SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .en_i(en), .delay_i(delay), .fb_mode_i(fb),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .done_o(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int sat(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction
    // y(n) = sat(x(n) + stored(n-D)/2^SH); flush appends zero inputs
    task automatic model(input int d, input bit f, input int xs[$], output int ys[$]);
        int st[$];
        int nf, xv, t, yv;
        ys = {};
        nf = (d == 0) ? 0 : f ? DEPTH : (xs.size() < d ? xs.size() : d);
        for (int i = 0; i < xs.size() + nf; i++) begin
            xv = (i < xs.size()) ? xs[i] : 0;
            t  = (d != 0 && i >= d) ? st[i-d] : 0;
            yv = sat(xv + (t >>> SH));
            st.push_back(f ? yv : xv);
            ys.push_back(yv);
        end
    endtask
    task automatic run(input string tag, input int d, input bit f, input int xs[$], input bit bp,
                       output int got[$], output int lat);
        int idx = 0, cyc = 0, dn = 0, drop = 0;
        int exp[$];
        got = {};
        delay = AW'(d);
        fb = f;
        en = 1'b1;
        while (dn == 0 && cyc < 20 * (xs.size() + DEPTH) + 200) begin
            @(negedge clk);
            cyc++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == xs.size() && en) begin
                en = 1'b0;
                drop = cyc;
            end
            in_valid = en && idx < xs.size() && $urandom_range(0, 3) != 0;
            in_data = (idx < xs.size()) ? DW'(xs[idx]) : '0;
            #1;
            if (out_valid && out_ready) got.push_back(int'(out_data));
            if (out_valid && !out_ready && in_ready) bp_viol++;
            if (in_valid && in_ready) idx++;
            if (done) dn++;
        end
        lat = cyc - drop;
        repeat (4) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = 1'b0;
            #1;
            if (out_valid) got.push_back(int'(out_data));
            if (done) dn++;
        end
        model(d, f, xs, exp);
        chk($sformatf("%s_done", tag), dn, 1);
        chk($sformatf("%s_len", tag), got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_y%0d", tag, i), got[i], exp[i]);
    endtask
    initial begin
        int xs[$];
        int g1[$];
        int g2[$];
        int lat;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        xs = {1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run("echo", 4, 0, xs, 0, g1, lat);
        chk("echo_first", g1.size() > 4 ? g1[0] : -1, 1000);
        chk("echo_tap", g1.size() > 4 ? g1[4] : -1, 500);
        chk("echo_count", g1.size(), 16);
        xs = {1024, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run("fb", 3, 1, xs, 0, g1, lat);
        chk("fb_n9", g1.size() > 9 ? g1[9] : -1, 128);
        chk("fb_count", g1.size(), 12 + DEPTH);
        xs = {};
        repeat (10) xs.push_back(30000);
        run("satp", 1, 0, xs, 0, g1, lat);
        chk("satp_last", g1.size() > 9 ? g1[9] : -1, 32767);
        xs = {};
        repeat (10) xs.push_back(-30000);
        run("satn", 1, 0, xs, 1, g1, lat);
        chk("satn_last", g1.size() > 9 ? g1[9] : -1, -32768);
        xs = {};
        repeat (60) xs.push_back($urandom_range(0, 65535) - 32768);
        run("bp_free", 8, 0, xs, 0, g1, lat);
        run("bp_rand", 8, 0, xs, 1, g2, lat);
        chk("bp_same_len", g2.size(), g1.size());
        for (int i = 0; i < g1.size() && i < g2.size(); i++) chk($sformatf("bp_same%0d", i), g2[i], g1[i]);
        xs = {};
        for (int n = 0; n < 40; n++) xs.push_back(n);
        run("ramp", 15, 0, xs, 0, g1, lat);
        chk("ramp_n39", g1.size() > 39 ? g1[39] : -1, 39 + 12);
        xs = {};
        repeat (2100) xs.push_back($urandom_range(0, 65535) - 32768);
        run("wrap", 1000, 0, xs, 1, g1, lat);
        for (int r = 0; r < 4; r++) begin
            xs = {};
            repeat (80) xs.push_back($urandom_range(0, 65535) - 32768);
            run($sformatf("rnd%0d", r), $urandom_range(0, 40), 1'($urandom_range(0, 1)), xs, 1'($urandom_range(0, 1)), g1, lat);
        end
        delay = AW'(8);
        fb = 1'b0;
        en = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            in_data = DW'($urandom);
        end
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_out_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        xs = {};
        repeat (20) xs.push_back($urandom_range(0, 65535) - 32768);
        run("bypass", 0, 0, xs, 0, g1, lat);
        chk("bypass_done_fast", lat <= 3, 1);
        chk("bp_in_ready_stall", bp_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
